cordic_vector: RTL and testbench
================================

// Module: cordic_vector
// PURPOSE
//  Iterative CORDIC in vectoring mode. It is the inverse of the pipelined rotation cordic
//  already in the codebase: it takes a cartesian pair (x, y) and returns the magnitude and the angle theda.
//  It sits after the rotation stage, so a rotated vector can be converted back to polar form for checking.
//  The block uses one shared shift-add datapath for all iterations, with a valid/ready handshake on each side.
// PARAMETERS
//  W     12  width of x/y/theda; signed two's complement
//  ITER  10  number of micro-rotations, i = 0..ITER-1; legal range 1..12
// PORTS
//  clk        in   1     clock; every transition happens on the rising edge
//  rst        in   1     synchronous reset, active-high
//  in_valid   in   1     x/y present on the input
//  in_ready   out  1     block can accept an input (high in IDLE only)
//  x          in   W     signed x coordinate
//  y          in   W     signed y coordinate
//  out_valid  out  1     result present; held until accepted
//  out_ready  in   1     consumer accepts the result
//  mag_out    out  W+2   unsigned magnitude, gain K included (about 1.6468*sqrt(x^2+y^2))
//  theda_out  out  W     signed angle; full scale +/-2^(W-1) = +/-pi
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, mag_out=0, theda_out=0; state returns to IDLE.
//  Reset takes priority over every other event, including in the middle of RUN.
//  A reset during RUN or DONE drops the work in progress; no out_valid pulse follows it.
//  FSM states:
//   IDLE: on in_valid & in_ready, latch x/y sign-extended to W+2 bits, apply quadrant pre-rotation, go to RUN with i=0.
//   RUN: one micro-rotation per cycle. After the rotation with i=ITER-1, register the results and go to DONE.
//   DONE: out_valid=1. On out_ready, go to IDLE with out_valid cleared.
//         mag_out and theda_out stay stable until the next result is registered.
//  Latency: accept at edge N gives out_valid=1 after edge N+ITER+1.
//  in_ready is 0 during RUN and DONE; in_valid in those states is ignored, not queued.
//  When in_valid and out_ready are both high in DONE, only the output handshake happens.
//  Re-accept is possible at the earliest one cycle after the out_ready edge.
//  Pre-rotation (pi/2 = 2^(W-2)):
//   x>=0:        x0=x,  y0=y,  z0=0
//   x<0, y>=0:   x0=y,  y0=-x, z0=+pi/2
//   x<0, y<0:    x0=-y, y0=x,  z0=-pi/2
//  Micro-rotation: d = (y>=0) ? +1 : -1
//   x += d*(y>>>i);  y -= d*(x>>>i);  z += d*ATAN[i]
//   Shifts are arithmetic on the old x/y values; both updates happen simultaneously.
//  Widths: x/y internal W+2 signed, so -2^(W-1) negates and the K gain fits without overflow.
//   z is W bits and wraps mod 2^W; +pi and -pi are both the encoding -2^(W-1).
//   mag_out = final x, which is always >=0, output as unsigned W+2 bits.
//   There is no gain compensation and no rounding; lower bits are truncated by the shifts.
//  Input x=0, y=0: mag_out=0; theda_out is whatever the iterations leave, which is defined but meaningless.
// STRUCTURE
//  Package cordic_pkg: ATAN table in units of pi/2^(W-1) for W=12:
//   512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0
//  The package also holds the FSM state encoding (IDLE/RUN/DONE), the PI_HALF constant, and K=1.6468 as a
//  comment for benches.
//  One sub-module, cordic_vec_step: combinational single micro-rotation (x, y, z, i) -> (x', y', z').
//  Everything else (FSM, iteration counter, registers) stays in cordic_vector.
// TESTING
//  1 x=1000, y=0 -> after 11 cycles: mag_out=1647+/-3, theda_out=0+/-3.
//  2 x=0, y=1000 -> mag_out=1647+/-3, theda_out=1024+/-3.
//  3 x=-1000, y=0 -> theda_out within 3 LSB of -2048 mod 4096 (wraps near +/-pi); mag_out=1647+/-3.
//  4 x=-2048, y=-2048 -> mag_out=4770+/-4, theda_out=-1536+/-3; no overflow.
//  5 Backpressure: hold out_ready=0 for 20 cycles.
//    out_valid stays 1, outputs stay stable, in_ready stays 0, and in_valid pulses are dropped.
//    After out_ready=1, in_ready rises on the next cycle.
//  6 Reset in RUN: assert rst at iteration 4.
//    Next cycle: in_ready=1, out_valid=0, outputs 0; no stale result appears.
//    A fresh x=600, y=800 then returns mag_out=1647+/-3, theda_out=604+/-3.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: FSM encoding, arctangent table and pi/2 scale.
// Gain of ITER micro-rotations is K ~= 1.6468, so mag_out ~= 1.6468*sqrt(x^2+y^2).
package cordic_pkg;

    localparam int ITER_MAX = 12;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full scale 2^(W-1) is pi, so pi/2 is 2^(W-2).
    function automatic int pi_half(input int w);
        return 1 << (w - 2);
    endfunction

    localparam int PI_HALF = pi_half(12);

    // atan(2^-i) in units of pi/2^11, rescaled when W differs from 12.
    function automatic int atan_lut(input int i, input int w);
        int a;
        case (i)
            0:       a = 512;
            1:       a = 302;
            2:       a = 160;
            3:       a = 81;
            4:       a = 41;
            5:       a = 20;
            6:       a = 10;
            7:       a = 5;
            8:       a = 3;
            9:       a = 1;
            10:      a = 1;
            default: a = 0;
        endcase
        if (w >= 12) return a << (w - 12);
        return a >> (12 - w);
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the angle in z.
module cordic_vec_step
    import cordic_pkg::*;
#(
    parameter int W = 12
) (
    input  logic signed [W+1:0]    x,
    input  logic signed [W+1:0]    y,
    input  logic signed [W-1:0]    z,
    input  logic        [CNT_W-1:0] i,
    output logic signed [W+1:0]    xn,
    output logic signed [W+1:0]    yn,
    output logic signed [W-1:0]    zn
);

    logic signed [W+1:0] xs;
    logic signed [W+1:0] ys;
    logic signed [W-1:0] at;

    assign xs = x >>> i;
    assign ys = y >>> i;
    assign at = W'(atan_lut(int'(i), W));

    always_comb begin
        xn = x;
        yn = y;
        zn = z;
        if (!y[W+1]) begin
            xn = x + ys;
            yn = y - xs;
            zn = z + at;
        end else begin
            xn = x - ys;
            yn = y + xs;
            zn = z - at;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (x, y) -> (magnitude with gain K, angle), one micro-rotation per cycle.
//   state | meaning
//   IDLE  | in_ready=1, waiting for an input handshake
//   RUN   | iterating; down-counter cnt reaches 0 after the last micro-rotation
//   DONE  | out_valid=1, results held until out_ready
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int W    = 12,
    parameter int ITER = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+1:0]        mag_out,
    output logic signed [W-1:0] theda_out
);

    localparam int XW = W + 2;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ITER);
    localparam logic signed [W-1:0] Z_POS = W'(pi_half(W));
    localparam logic signed [W-1:0] Z_NEG = W'(-pi_half(W));

    state_t state, state_nxt;

    logic signed [XW-1:0] xr, yr, xe, ye, x0, y0, xn, yn;
    logic signed [W-1:0]  zr, z0, zn;
    logic [CNT_W-1:0]     cnt, idx;
    logic                 accept, tc;

    assign xe = {{2{x[W-1]}}, x};
    assign ye = {{2{y[W-1]}}, y};
    assign tc  = (cnt == '0);
    assign idx = CNT_LOAD - cnt;

    // Fold the left half-plane into the right so the iterations converge.
    always_comb begin
        x0 = xe;
        y0 = ye;
        z0 = '0;
        if (x[W-1]) begin
            if (!y[W-1]) begin
                x0 = ye;
                y0 = -xe;
                z0 = Z_POS;
            end else begin
                x0 = -ye;
                y0 = xe;
                z0 = Z_NEG;
            end
        end
    end

    cordic_vec_step #(.W(W)) u_step (
        .x  (xr),
        .y  (yr),
        .z  (zr),
        .i  (idx),
        .xn (xn),
        .yn (yn),
        .zn (zn)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (tc) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            cnt       <= '0;
            mag_out   <= '0;
            theda_out <= '0;
        end else if (accept) begin
            xr  <= x0;
            yr  <= y0;
            zr  <= z0;
            cnt <= CNT_LOAD;
        end else if (state == RUN) begin
            if (tc) begin
                mag_out   <= xr;
                theda_out <= zr;
            end else begin
                xr  <= xn;
                yr  <= yn;
                zr  <= zn;
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: table of polar conversions plus handshake and reset sequences.
module tb_cordic_vector;

    localparam int W    = 12;
    localparam int ITER = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic                out_valid;
    logic                out_ready;
    logic [W+1:0]        mag_out;
    logic signed [W-1:0] theda_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_vector #(.W(W), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .theda_out (theda_out)
    );

    typedef struct {
        string name;
        int    xv;
        int    yv;
        int    mag;
        int    mag_tol;
        int    th;
        int    th_tol;
        bit    th_chk;
    } vec_t;

    vec_t vecs[8];

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Angle differences are taken mod 2^W so +pi and -pi compare as neighbours.
    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        int d;
        logic signed [W-1:0] dw;
        checks++;
        dw = W'(act - exp);
        d  = int'(dw);
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic chk_mag(input string name, input int exp, input int tol);
        int d;
        checks++;
        d = int'(mag_out) - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, int'(mag_out), exp, tol);
        end
    endtask

    task automatic apply(input string name, input int xv, input int yv);
        @(negedge clk);
        chk_eq({name, "_in_ready"}, int'(in_ready), 1);
        x        = W'(xv);
        y        = W'(yv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 50 && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no out_valid in %0d cycles, want it after %0d", name, n, ITER + 1);
        end else begin
            chk_eq({name, "_latency"}, n, ITER + 1);
        end
    endtask

    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_eq({name, "_out_valid_clr"}, int'(out_valid), 0);
        chk_eq({name, "_in_ready_set"}, int'(in_ready), 1);
    endtask

    initial begin
        bit ok;
        int m_hold;
        int t_hold;
        int stray;

        vecs[0] = '{"x1000_y0",       1000,     0, 1647, 3,     0, 3, 1'b1};
        vecs[1] = '{"x0_y1000",          0,  1000, 1647, 3,  1024, 3, 1'b1};
        vecs[2] = '{"xm1000_y0",     -1000,     0, 1647, 3, -2048, 3, 1'b1};
        vecs[3] = '{"xm2048_ym2048", -2048, -2048, 4770, 4, -1536, 3, 1'b1};
        vecs[4] = '{"x1000_y1000",    1000,  1000, 2329, 4,   512, 3, 1'b1};
        vecs[5] = '{"x1000_ym1000",   1000, -1000, 2329, 4,  -512, 3, 1'b1};
        vecs[6] = '{"xm1000_y1000",  -1000,  1000, 2329, 4,  1536, 3, 1'b1};
        vecs[7] = '{"zero",              0,     0,    0, 0,     0, 0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_in_ready",  int'(in_ready),  1);
        chk_eq("reset_out_valid", int'(out_valid), 0);
        chk_eq("reset_mag",       int'(mag_out),   0);
        chk_eq("reset_theda",     int'(theda_out), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            apply(vecs[k].name, vecs[k].xv, vecs[k].yv);
            wait_result(vecs[k].name, ok);
            if (ok) begin
                chk_mag({vecs[k].name, "_mag"}, vecs[k].mag, vecs[k].mag_tol);
                if (vecs[k].th_chk)
                    chk_tol({vecs[k].name, "_theda"}, int'(theda_out), vecs[k].th, vecs[k].th_tol);
            end
            release_out(vecs[k].name);
        end

        // Backpressure: result held, input pulses ignored, nothing queued afterwards.
        apply("bp", 1000, 0);
        wait_result("bp", ok);
        chk_mag("bp_mag", 1647, 3);
        m_hold = int'(mag_out);
        t_hold = int'(theda_out);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = (c % 3 == 0);
            x        = -12'sd500;
            y        = 12'sd300;
            @(posedge clk);
            #1;
            chk_eq("bp_out_valid", int'(out_valid), 1);
            chk_eq("bp_in_ready",  int'(in_ready),  0);
            chk_eq("bp_mag_hold",  int'(mag_out),   m_hold);
            chk_eq("bp_th_hold",   int'(theda_out), t_hold);
        end
        in_valid = 1'b0;
        release_out("bp");
        stray = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        chk_eq("bp_no_queued", stray, 0);

        // in_valid together with out_ready in DONE: only the output side moves.
        apply("both", 0, 1000);
        wait_result("both", ok);
        chk_tol("both_theda_first", int'(theda_out), 1024, 3);
        @(negedge clk);
        x         = 12'sd1000;
        y         = 12'sd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_eq("both_out_valid", int'(out_valid), 0);
        chk_eq("both_in_ready",  int'(in_ready),  1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_eq("reaccept_in_ready", int'(in_ready), 0);
        wait_result("reaccept", ok);
        chk_mag("reaccept_mag", 1647, 3);
        chk_tol("reaccept_theda", int'(theda_out), 0, 3);
        release_out("reaccept");

        // Reset in the middle of RUN drops the work in progress.
        apply("rstrun", 1000, 1000);
        repeat (4) @(posedge clk);
        #1;
        chk_eq("rstrun_busy", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("rstrun_in_ready",  int'(in_ready),  1);
        chk_eq("rstrun_out_valid", int'(out_valid), 0);
        chk_eq("rstrun_mag",       int'(mag_out),   0);
        chk_eq("rstrun_theda",     int'(theda_out), 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        chk_eq("rstrun_no_stale", stray, 0);
        apply("fresh", 600, 800);
        wait_result("fresh", ok);
        chk_mag("fresh_mag", 1647, 3);
        chk_tol("fresh_theda", int'(theda_out), 604, 3);
        release_out("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
